// File: rtl/clock_phase_gen.sv
// clock_phase_gen: divides clk into 4-quarter instruction cycles with clk_e/clk_s strobes, step_tick and run/halt/single-step control.
// Optional cycle counter enabled by defining CYCLE_COUNTER_EN.
module clock_phase_gen #(
  parameter int QDIV  = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step_req,
  output logic             clk_e,
  output logic             clk_s,
  output logic             step_tick,
  output logic [1:0]       phase,
  output logic             busy
`ifdef CYCLE_COUNTER_EN
  ,
  output logic [CNT_W-1:0] cycle_count
`endif
);
  localparam int SW = QDIV > 1 ? $clog2(QDIV) : 1;
  localparam logic [SW-1:0] SUB_MAX = SW'(QDIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, SINGLE} state_t;

  if (QDIV < 1 || CNT_W < 1) begin : g_bad_param
    $error("clock_phase_gen: QDIV and CNT_W must be >= 1");
  end

  state_t        state_q, state_d;
  logic [SW-1:0] sub_q, sub_d;
  logic [1:0]    phase_q, phase_d;
  logic          clk_e_q, clk_e_d;
  logic          clk_s_q, clk_s_d;
  logic          step_tick_q, step_tick_d;
  logic          busy_q, busy_d;
  logic          last;

  assign last = state_q != IDLE && sub_q == SUB_MAX && phase_q == 2'd3;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // RUN chains cycles back-to-back; SINGLE always falls back to IDLE
  always_comb begin
    state_d = state_q == IDLE ? (run ? RUN : step_req ? SINGLE : IDLE)
            : last ? ((state_q == RUN && run) ? RUN : IDLE)
            : state_q;
  end

  always_comb begin
    sub_d       = (state_q == IDLE || last || sub_q == SUB_MAX) ? '0 : sub_q + 1'b1;
    phase_d     = (state_q == IDLE || last) ? 2'd0 : (sub_q == SUB_MAX ? phase_q + 2'd1 : phase_q);
    busy_d      = state_d != IDLE;
    clk_e_d     = busy_d && phase_d != 2'd3;
    clk_s_d     = busy_d && phase_d == 2'd1;
    step_tick_d = busy_d && phase_d == 2'd3 && sub_d == SUB_MAX;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sub_q       <= '0;
      phase_q     <= 2'd0;
      busy_q      <= 1'b0;
      clk_e_q     <= 1'b0;
      clk_s_q     <= 1'b0;
      step_tick_q <= 1'b0;
    end else begin
      sub_q       <= sub_d;
      phase_q     <= phase_d;
      busy_q      <= busy_d;
      clk_e_q     <= clk_e_d;
      clk_s_q     <= clk_s_d;
      step_tick_q <= step_tick_d;
    end
  end

  assign clk_e     = clk_e_q;
  assign clk_s     = clk_s_q;
  assign step_tick = step_tick_q;
  assign phase     = phase_q;
  assign busy      = busy_q;

`ifdef CYCLE_COUNTER_EN
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q + CNT_W'(step_tick_q);
  end

  always_ff @(posedge clk) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign cycle_count = count_q;
`endif
endmodule

// File: tb/tb_clock_phase_gen.sv
// tb_clock_phase_gen: checks QDIV=4 and QDIV=1 instances against a cycle-position model, plus directed literal timing checks.
module tb_clock_phase_gen;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic run = 1'b0;
  logic step_req = 1'b0;
  logic       ce [2];
  logic       cs [2];
  logic       tk [2];
  logic       bz [2];
  logic [1:0] ph [2];
`ifdef CYCLE_COUNTER_EN
  logic [CW-1:0] cc [2];
  int m_cnt [2];
`endif

  int n_chk = 0;
  int n_fail = 0;
  int m_pos [2];
  bit m_act [2];
  bit m_free [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    clock_phase_gen #(.QDIV(g == 0 ? 4 : 1), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .run(run), .step_req(step_req),
      .clk_e(ce[g]), .clk_s(cs[g]), .step_tick(tk[g]), .phase(ph[g]), .busy(bz[g])
`ifdef CYCLE_COUNTER_EN
      , .cycle_count(cc[g])
`endif
    );
  end

  function automatic int qd(int i);
    return i == 0 ? 4 : 1;
  endfunction

  // model: a cycle is a position 0..4*QDIV-1; strobes follow from quarter arithmetic
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        m_act[i] <= 1'b0;
        m_pos[i] <= 0;
        m_free[i] <= 1'b0;
`ifdef CYCLE_COUNTER_EN
        m_cnt[i] <= 0;
`endif
      end else if (!m_act[i]) begin
        if (run || step_req) begin
          m_act[i] <= 1'b1;
          m_free[i] <= run;
          m_pos[i] <= 0;
        end
      end else if (m_pos[i] == 4 * qd(i) - 1) begin
        m_pos[i] <= 0;
        m_act[i] <= m_free[i] && run;
`ifdef CYCLE_COUNTER_EN
        m_cnt[i] <= m_cnt[i] + 1;
`endif
      end else begin
        m_pos[i] <= m_pos[i] + 1;
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      int q, p;
      bit a;
      q = qd(i);
      p = m_pos[i];
      a = m_act[i];
      chk($sformatf("busy[%0d]", i), 32'(bz[i]), 32'(a));
      chk($sformatf("phase[%0d]", i), 32'(ph[i]), a ? p / q : 0);
      chk($sformatf("clk_e[%0d]", i), 32'(ce[i]), 32'(a && p < 3 * q));
      chk($sformatf("clk_s[%0d]", i), 32'(cs[i]), 32'(a && p >= q && p < 2 * q));
      chk($sformatf("step_tick[%0d]", i), 32'(tk[i]), 32'(a && p == 4 * q - 1));
`ifdef CYCLE_COUNTER_EN
      chk($sformatf("cycle_count[%0d]", i), 32'(cc[i]), m_cnt[i] % (1 << CW));
`endif
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    reset = 1'b0;
    run = 1'b1;
    repeat (3) tick();
    chk("rst_clk_e", 32'(ce[0]), 0);
    chk("rst_busy", 32'(bz[0]), 0);
    chk("rst_phase", 32'(ph[0]), 0);
    chk("rst_tick", 32'(tk[0]), 0);
    reset = 1'b1;
    tick();
    chk("start_clk_e", 32'(ce[0]), 1);
    chk("start_busy", 32'(bz[0]), 1);
    chk("start_phase", 32'(ph[0]), 0);
    for (int t = 2; t <= 48; t++) begin
      tick();
      chk("free_tick", 32'(tk[0]), 32'(t % 16 == 0));
      chk("free_clk_s", 32'(cs[0]), 32'((t - 1) % 16 / 4 == 1));
      chk("free_clk_e", 32'(ce[0]), 32'((t - 1) % 16 < 12));
    end
    for (int t = 49; t <= 66; t++) begin
      tick();
      if (t == 54) run = 1'b0;
      chk("drop_tick", 32'(tk[0]), 32'(t == 64));
      chk("drop_busy", 32'(bz[0]), 32'(t <= 64));
    end
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    chk("single_start", 32'(bz[0]), 1);
    for (int t = 68; t <= 90; t++) begin
      tick();
      step_req = (t == 74);
      chk("single_tick", 32'(tk[0]), 32'(t == 82));
      chk("single_busy", 32'(bz[0]), 32'(t <= 82));
    end
    run = 1'b1;
    for (int t = 91; t <= 101; t++) begin
      tick();
      if (t == 100) reset = 1'b0;
      chk("abort_tick", 32'(tk[0]), 0);
      if (t == 101) begin
        chk("abort_busy", 32'(bz[0]), 0);
        chk("abort_clk_e", 32'(ce[0]), 0);
        chk("abort_phase", 32'(ph[0]), 0);
      end
    end
    reset = 1'b1;
    run = 1'b0;
    for (int t = 0; t < 4000; t++) begin
      tick();
      if ($urandom_range(19) == 0) run = ~run;
      step_req = $urandom_range(7) == 0;
      reset = $urandom_range(299) != 0;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
